// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dual-port data-memory arbiter.
// The address range check is built only when DMEM_ARB_ADDR_CHECK_EN is defined.
package dmem_arb_pkg;

  localparam int DW            = 8;
  localparam int AW            = 8;
  localparam int DEPTH_DEFAULT = 64;

  // Arbiter FSM: free arbitration, or the grant held by r0 / r1.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin winner pick.
// ptr_i names the requester served last, and mask_i lists which requesters
// may be granted this cycle.
module dmem_rr_pick (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  input  logic [1:0] mask_i,
  output logic [1:0] gnt_o
);

  logic [1:0] elig;

  assign elig = req_i & mask_i;

  // Single eligible requester wins outright; on a tie the one not served last wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    gnt_o = 2'b00;
    case (elig)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arb.sv
// Data-memory arbiter: r0 is the core load/store port and r1 is the DMA/host port.
// A requester can hold the grant with its lock input, for at most LOCK_MAX
// grants in a row.
// Define DMEM_ARB_ADDR_CHECK_EN to reject accesses at addr >= DEPTH.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic          r0_lock,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  input  logic          r1_lock,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  output logic          r0_err,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          r1_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_dat_in,
  input  logic [DW-1:0] mem_dat_out
);

  localparam int            CW       = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_CAP = CW'(LOCK_MAX);

  if (DEPTH < 1 || DEPTH > (1 << AW) || LOCK_MAX < 1) begin : g_param_check
    $error("dmem_arb: DEPTH must be 1..2**AW and LOCK_MAX at least 1");
  end

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0][DW-1:0] rdata_q, rdata_d;

  logic [1:0]        req;
  logic [1:0]        lock_mask;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              win;
  logic              win_we;
  logic              win_lock;
  logic [AW-1:0]     win_addr;
  logic [DW-1:0]     win_wdata;
  logic              addr_bad;
  logic [CW-1:0]     cnt_inc;

  assign req = {r1_req, r0_req};

  // A held lock lets only its owner through; reset blocks every grant.
  always_comb begin
    lock_mask = 2'b11;
    case (state_q)
      LOCK0:   lock_mask = 2'b01;
      LOCK1:   lock_mask = 2'b10;
      default: lock_mask = 2'b11;
    endcase
    if (reset) lock_mask = 2'b00;
  end

  dmem_rr_pick u_pick (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .mask_i (lock_mask),
    .gnt_o  (gnt)
  );

  assign r0_gnt    = gnt[0];
  assign r1_gnt    = gnt[1];
  assign any_gnt   = |gnt;
  assign win       = gnt[1];
  assign win_we    = win ? r1_we    : r0_we;
  assign win_lock  = win ? r1_lock  : r0_lock;
  assign win_addr  = win ? r1_addr  : r0_addr;
  assign win_wdata = win ? r1_wdata : r0_wdata;

`ifdef DMEM_ARB_ADDR_CHECK_EN
  assign addr_bad = any_gnt && (int'(win_addr) >= DEPTH);
`else
  assign addr_bad = 1'b0;
`endif

  // The memory bus carries the winner's access; it is parked at zero when nothing is granted.
  assign mem_addr   = any_gnt ? win_addr  : '0;
  assign mem_dat_in = any_gnt ? win_wdata : '0;
  assign mem_wr_en  = any_gnt & win_we & ~addr_bad;

  assign cnt_inc = cnt_q + 1'b1;

  // Lock FSM, round-robin pointer and consecutive-lock counter.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    // The lock owner dropping its request frees the arbiter (no grant this cycle).
    if ((state_q == LOCK0 && !r0_req) || (state_q == LOCK1 && !r1_req)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
    if (any_gnt) begin
      ptr_d = win;
      if (win_lock && cnt_inc < LOCK_CAP) begin
        state_d = win ? LOCK1 : LOCK0;
        cnt_d   = cnt_inc;
      end else begin
        // Lock released, or LOCK_MAX grants used up: back to arbitration with
        // the pointer already favouring the other requester.
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  // Read return path: capture the memory data at the grant edge.
  always_comb begin
    rvalid_d = 2'b00;
    rdata_d  = rdata_q;
    if (any_gnt && !win_we) begin
      rvalid_d[win] = 1'b1;
      rdata_d[win]  = addr_bad ? '0 : mem_dat_out;
    end
  end

  // Control and read-return registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with <= so every flop samples pre-edge values and the order of statements cannot matter.
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b1;
      cnt_q    <= '0;
      rvalid_q <= 2'b00;
      // NOTE: rdata is a plain two-entry register (not a memory array), so it is reset like any other flop.
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // A read granted just before reset rises is dropped, not returned.
  assign r0_rvalid = rvalid_q[0] & ~reset;
  assign r1_rvalid = rvalid_q[1] & ~reset;
  assign r0_rdata  = rdata_q[0];
  assign r1_rdata  = rdata_q[1];

`ifdef DMEM_ARB_ADDR_CHECK_EN
  logic [1:0] err_q, err_d;

  // One-cycle error pulse for an out-of-range access.
  always_comb begin
    err_d = 2'b00;
    if (addr_bad) err_d[win] = 1'b1;
  end

  // Error pulse register.
  always_ff @(posedge clk) begin
    if (reset) err_q <= 2'b00;
    else       err_q <= err_d;
  end

  assign r0_err = err_q[0] & ~reset;
  assign r1_err = err_q[1] & ~reset;
`else
  assign r0_err = 1'b0;
  assign r1_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb with a read-data scoreboard and a memory model.
// The address-check cases adapt when DMEM_ARB_ADDR_CHECK_EN is defined.
module tb_dmem_arb;

  localparam int TB_DEPTH = 64;

  typedef struct {
    int         due;
    logic [7:0] data;
  } rd_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       r0_req = 1'b0, r0_we = 1'b0, r0_lock = 1'b0;
  logic [7:0] r0_addr = '0, r0_wdata = '0;
  logic       r1_req = 1'b0, r1_we = 1'b0, r1_lock = 1'b0;
  logic [7:0] r1_addr = '0, r1_wdata = '0;
  logic       r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [7:0] r0_rdata, r1_rdata;
  logic [7:0] mem_addr, mem_dat_in, mem_dat_out;
  logic       mem_wr_en;

  // Staged stimulus, applied at the next falling edge by tick().
  logic       s_reset = 1'b1;
  logic       s0_req = 1'b0, s0_we = 1'b0, s0_lock = 1'b0;
  logic [7:0] s0_addr = '0, s0_wdata = '0;
  logic       s1_req = 1'b0, s1_we = 1'b0, s1_lock = 1'b0;
  logic [7:0] s1_addr = '0, s1_wdata = '0;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  rd_t        q0[$];
  rd_t        q1[$];
  int         err_due0 = -1;
  int         err_due1 = -1;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;

  dmem_arb #(.DEPTH(TB_DEPTH), .LOCK_MAX(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .r0_req      (r0_req),
    .r0_we       (r0_we),
    .r0_addr     (r0_addr),
    .r0_wdata    (r0_wdata),
    .r0_lock     (r0_lock),
    .r1_req      (r1_req),
    .r1_we       (r1_we),
    .r1_addr     (r1_addr),
    .r1_wdata    (r1_wdata),
    .r1_lock     (r1_lock),
    .r0_gnt      (r0_gnt),
    .r0_rvalid   (r0_rvalid),
    .r0_rdata    (r0_rdata),
    .r0_err      (r0_err),
    .r1_gnt      (r1_gnt),
    .r1_rvalid   (r1_rvalid),
    .r1_rdata    (r1_rdata),
    .r1_err      (r1_err),
    .mem_addr    (mem_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_dat_in  (mem_dat_in),
    .mem_dat_out (mem_dat_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // External memory: combinational read, write on the rising edge.
  assign mem_dat_out = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_dat_in;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_r0(input logic req, we, input logic [7:0] addr, wdata, input logic lock);
    s0_req = req; s0_we = we; s0_addr = addr; s0_wdata = wdata; s0_lock = lock;
  endtask

  task automatic set_r1(input logic req, we, input logic [7:0] addr, wdata, input logic lock);
    s1_req = req; s1_we = we; s1_addr = addr; s1_wdata = wdata; s1_lock = lock;
  endtask

  // One clock cycle: apply staged inputs, check grants and memory bus against
  // the expected winner, then update the memory model and scoreboard.
  task automatic tick(input logic eg0, input logic eg1, input string tag);
    logic       w, we, bad, any;
    logic [7:0] a, d;
    @(negedge clk);
    reset = s_reset;
    r0_req = s0_req; r0_we = s0_we; r0_addr = s0_addr; r0_wdata = s0_wdata; r0_lock = s0_lock;
    r1_req = s1_req; r1_we = s1_we; r1_addr = s1_addr; r1_wdata = s1_wdata; r1_lock = s1_lock;
    if (s_reset) begin
      q0.delete(); q1.delete();
      err_due0 = -1; err_due1 = -1;
    end
    #1;
    check(r0_gnt, eg0, {tag, "_gnt0"});
    check(r1_gnt, eg1, {tag, "_gnt1"});
    any = eg0 | eg1;
    w   = eg1;
    we  = w ? s1_we    : s0_we;
    a   = w ? s1_addr  : s0_addr;
    d   = w ? s1_wdata : s0_wdata;
    bad = 1'b0;
`ifdef DMEM_ARB_ADDR_CHECK_EN
    bad = any && (int'(a) >= TB_DEPTH);
`endif
    check(mem_wr_en,  any & we & ~bad, {tag, "_wr_en"});
    check(mem_addr,   any ? a : 8'h00, {tag, "_addr"});
    check(mem_dat_in, any ? d : 8'h00, {tag, "_dat_in"});
    if (any) begin
      if (we && !bad) ref_mem[a] = d;
      if (!we) begin
        if (w) q1.push_back('{cyc + 1, bad ? 8'h00 : ref_mem[a]});
        else   q0.push_back('{cyc + 1, bad ? 8'h00 : ref_mem[a]});
      end
      if (bad) begin
        if (w) err_due1 = cyc + 1;
        else   err_due0 = cyc + 1;
      end
    end
  endtask

  // Read-return and error monitor, sampled mid-cycle after stimulus settles.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        if (q0.size() > 0 && q0[0].due == cyc) begin
          check(r0_rvalid, 1'b1, "r0_rvalid");
          check(r0_rdata, q0[0].data, "r0_rdata");
          void'(q0.pop_front());
        end else begin
          check(r0_rvalid, 1'b0, "r0_rvalid_idle");
        end
        if (q1.size() > 0 && q1[0].due == cyc) begin
          check(r1_rvalid, 1'b1, "r1_rvalid");
          check(r1_rdata, q1[0].data, "r1_rdata");
          void'(q1.pop_front());
        end else begin
          check(r1_rvalid, 1'b0, "r1_rvalid_idle");
        end
        check(r0_err, err_due0 == cyc, "r0_err");
        check(r1_err, err_due1 == cyc, "r1_err");
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i) ^ 8'h3C;
      ref_mem[i] = 8'(i) ^ 8'h3C;
    end

    // Reset, with r0 trying to write: nothing may be granted.
    s_reset = 1'b1;
    set_r0(1, 1, 8'd5, 8'hFF, 0);
    tick(0, 0, "rst_a");
    mon_en = 1'b1;
    tick(0, 0, "rst_b");
    s_reset = 1'b0;
    set_r0(0, 0, 8'd0, 8'h00, 0);
    tick(0, 0, "post_rst");
    check(r0_rdata, 8'h00, "rst_rdata0");
    check(r1_rdata, 8'h00, "rst_rdata1");

    // Write then read back on r0, one-cycle read latency.
    set_r0(1, 1, 8'd5, 8'hA5, 0);
    tick(1, 0, "w5");
    set_r0(1, 0, 8'd5, 8'h00, 0);
    tick(1, 0, "r5");
    set_r0(0, 0, 8'd0, 8'h00, 0);
    tick(0, 0, "r5_ret");
    tick(0, 0, "r5_hold");
    check(r0_rdata, 8'hA5, "rdata_hold");

    // Round robin after reset: r0 first, then strict alternation.
    s_reset = 1'b1;
    tick(0, 0, "rst_rr");
    s_reset = 1'b0;
    set_r0(1, 0, 8'd5, 8'h00, 0);
    set_r1(1, 0, 8'd6, 8'h00, 0);
    for (int i = 0; i < 6; i++) tick(i % 2 == 0, i % 2 == 1, "rr_alt");

    // Make r0 the last served, then r1 locks against a waiting r0.
    set_r1(0, 0, 8'd0, 8'h00, 0);
    set_r0(1, 1, 8'd10, 8'h11, 0);
    tick(1, 0, "pre_lock");
    set_r0(1, 0, 8'd10, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      set_r1(1, 1, 8'(20 + i), 8'(8'h60 + i), 1);
      tick(0, 1, "lock1_grant");
    end
    tick(1, 0, "lock1_forced_rel");
    set_r0(0, 0, 8'd0, 8'h00, 0);
    tick(0, 1, "lock1_rewin");
    // Owner drops its request: no grant that cycle, r0 wins the next.
    set_r1(0, 0, 8'd0, 8'h00, 0);
    set_r0(1, 0, 8'd27, 8'h00, 0);
    tick(0, 0, "lock1_drop");
    tick(1, 0, "after_drop");

    // r0 locks, r1 waits, r0 releases with lock=0: r1 wins next cycle.
    set_r0(1, 1, 8'd30, 8'h33, 1);
    tick(1, 0, "l0_enter");
    set_r1(1, 0, 8'd30, 8'h00, 0);
    set_r0(1, 1, 8'd31, 8'h34, 1);
    tick(1, 0, "l0_hold");
    set_r0(1, 1, 8'd32, 8'h35, 0);
    tick(1, 0, "l0_release");
    set_r0(1, 0, 8'd30, 8'h00, 0);
    tick(0, 1, "r1_after_rel");
    set_r1(0, 0, 8'd0, 8'h00, 0);
    tick(1, 0, "r0_after_r1");

    // Reset in the cycle after a granted read drops the read; writes during reset are blocked.
    set_r0(1, 1, 8'd40, 8'h44, 0);
    tick(1, 0, "w40");
    set_r0(1, 0, 8'd40, 8'h00, 0);
    tick(1, 0, "r40");
    s_reset = 1'b1;
    set_r0(1, 1, 8'd40, 8'hEE, 0);
    tick(0, 0, "rst_drop_a");
    tick(0, 0, "rst_drop_b");
    s_reset = 1'b0;
    set_r0(1, 0, 8'd40, 8'h00, 0);
    tick(1, 0, "r40_after_rst");

    // Address boundary: 63 is in range, 64 and above are out of range when checked.
    set_r0(1, 1, 8'd70, 8'h77, 0);
    tick(1, 0, "w70");
    set_r0(1, 0, 8'd200, 8'h00, 0);
    tick(1, 0, "r200");
    set_r0(0, 0, 8'd0, 8'h00, 0);
    set_r1(1, 0, 8'd63, 8'h00, 0);
    tick(0, 1, "r63");
    set_r1(1, 0, 8'd64, 8'h00, 0);
    tick(0, 1, "r64");
    set_r1(1, 0, 8'd70, 8'h00, 0);
    tick(0, 1, "r70");
    set_r1(0, 0, 8'd0, 8'h00, 0);
    tick(0, 0, "tail_a");
    tick(0, 0, "tail_b");
    tick(0, 0, "tail_c");

    check(q0.size(), 0, "sb0_drain");
    check(q1.size(), 0, "sb1_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
